// File: rtl/count_bcd_display_pkg.sv
// count_bcd_display_pkg: shared widths, FSM states and seven-segment table
package count_bcd_display_pkg;
    localparam int CNT_WIDTH = 14;
    localparam int BCD_DIGITS = 5;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;
endpackage

// File: rtl/count_bcd_display_if.sv
// count_bcd_display_if: count input, conversion handshake and display outputs
interface count_bcd_display_if
    import count_bcd_display_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int DIGITS = BCD_DIGITS
);
    logic [WIDTH-1:0]       count;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [4*DIGITS-1:0]    bcd;
    logic [DIGITS-1:0][6:0] hex;
    modport master (output count, start, input busy, done, bcd, hex);
    modport slave (input count, start, output busy, done, bcd, hex);
endinterface

// File: rtl/count_bcd_display_seg7.sv
// count_bcd_display_seg7: one BCD digit to active-low {g,f,e,d,c,b,a} segments
module count_bcd_display_seg7
    import count_bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    assign seg = (blank || digit > 4'd9) ? SEG_BLANK : SEG_TABLE[digit];
endmodule

// File: rtl/count_bcd_display.sv
// count_bcd_display: sequential double-dabble binary-to-BCD with latched seven-segment outputs
module count_bcd_display
    import count_bcd_display_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int DIGITS = BCD_DIGITS,
    parameter bit AUTO = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input logic clk,
    input logic reset,
    count_bcd_display_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int IW = $clog2(WIDTH);
    state_t                 state;
    logic [WIDTH-1:0]       bin;
    logic [WIDTH-1:0]       last;
    logic [BW-1:0]          accum;
    logic [BW-1:0]          adj;
    logic [BW-1:0]          bcd;
    logic [IW-1:0]          iter;
    logic                   busy;
    logic                   done;
    logic                   trig;
    logic [DIGITS-1:0]      blank;
    logic [DIGITS-1:0][6:0] hex;
    assign trig = bus.start || (AUTO && bus.count != last);
    // add-3 correction applied to every digit of the accumulator in parallel
    always_comb begin
        adj = accum;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = accum[4*k +: 4] >= 4'd5 ? accum[4*k +: 4] + 4'd3 : accum[4*k +: 4];
    end
    // digit k blanks only while it and every higher digit are zero; ones digit always shown
    always_comb begin
        logic run;
        run = 1'b1;
        blank = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run = run && bcd[4*k +: 4] == 4'd0;
            blank[k] = BLANK_LEADING && run;
        end
    end
    // conversion FSM: capture in IDLE, WIDTH correct-and-shift steps, then latch result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            bin   <= '0;
            last  <= '0;
            accum <= '0;
            bcd   <= '0;
            iter  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (trig) begin
                    bin   <= bus.count;
                    last  <= bus.count;
                    accum <= '0;
                    iter  <= '0;
                    busy  <= 1'b1;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    {accum, bin} <= {adj, bin} << 1;
                    iter  <= iter + 1'b1;
                    state <= iter == IW'(WIDTH - 1) ? S_LATCH : S_SHIFT;
                end
                S_LATCH: begin
                    bcd   <= accum;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        count_bcd_display_seg7 u_seg (
            .digit (bcd[4*g +: 4]),
            .blank (blank[g]),
            .seg   (hex[g])
        );
    end
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.bcd  = bcd;
    assign bus.hex  = hex;
endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display: directed stimulus with a cycle-level reference model and literal pins
module tb_count_bcd_display;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;
    int c;
    count_bcd_display_if bus ();
    count_bcd_display dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int pow10(input int k);
        int p = 1;
        repeat (k) p *= 10;
        return p;
    endfunction
    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r = '0;
        for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction
    function automatic logic [6:0] seg_exp(input int v, input int k);
        if (k > 0 && v < pow10(k)) return 7'h7F;
        case ((v / pow10(k)) % 10)
            0: return ~7'b0111111;
            1: return ~7'b0000110;
            2: return ~7'b1011011;
            3: return ~7'b1001111;
            4: return ~7'b1100110;
            5: return ~7'b1101101;
            6: return ~7'b1111101;
            7: return ~7'b0000111;
            8: return ~7'b1111111;
            9: return ~7'b1101111;
            default: return 7'h7F;
        endcase
    endfunction
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_cnt = 0;
    int m_val = 0;
    int m_last = 0;
    int m_shown = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_cnt   <= 0;
            m_val   <= 0;
            m_last  <= 0;
            m_shown <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 14) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_shown <= m_val;
                end
            end else if (bus.start || int'(bus.count) != m_last) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_val  <= int'(bus.count);
                m_last <= int'(bus.count);
            end
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("bcd", 32'(bus.bcd), 32'(to_bcd(m_shown)));
            for (int k = 0; k < 5; k++)
                check($sformatf("hex%0d", k), 32'(bus.hex[k]), 32'(seg_exp(m_shown, k)));
        end
    end
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 64);
        check("done_seen", 32'(bus.done), 32'd1);
    endtask
    initial begin
        bus.count = '0;
        bus.start = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        check("rst_hex0", 32'(bus.hex[0]), 32'h40);
        check("rst_hex4", 32'(bus.hex[4]), 32'h7F);
        reset = 1'b0;
        armed = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t1_no_done", 32'(bus.done), 32'd0);
        end
        check("t1_hex1", 32'(bus.hex[1]), 32'h7F);
        bus.count = 14'd12348;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t2_busy", 32'(bus.busy), 32'd1);
        wait_done(c);
        check("t2_latency", 32'(c), 32'd15);
        check("t2_bcd", 32'(bus.bcd), 32'h12348);
        check("t2_busy_low", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("t2_done_width", 32'(bus.done), 32'd0);
        bus.count = 14'd16383;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(c);
        check("t3_bcd_max", 32'(bus.bcd), 32'h16383);
        check("t3_hex4", 32'(bus.hex[4]), 32'h79);
        check("t3_hex0", 32'(bus.hex[0]), 32'h30);
        bus.count = 14'd9;
        wait_done(c);
        check("t3_bcd9", 32'(bus.bcd), 32'h00009);
        check("t3_hex0_9", 32'(bus.hex[0]), 32'h10);
        for (int k = 1; k < 5; k++) check($sformatf("t3_blank%0d", k), 32'(bus.hex[k]), 32'h7F);
        repeat (2) @(negedge clk);
        bus.count = 14'd100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.count = 14'd200;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_busy_e5", 32'(bus.busy), 32'd1);
        wait_done(c);
        check("t4_first_lat", 32'(c), 32'd10);
        check("t4_bcd100", 32'(bus.bcd), 32'h00100);
        wait_done(c);
        check("t4_gap", 32'(c), 32'd16);
        check("t4_bcd200", 32'(bus.bcd), 32'h00200);
        repeat (2) @(negedge clk);
        bus.count = 14'd777;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_done", 32'(bus.done), 32'd0);
        check("t5_bcd", 32'(bus.bcd), 32'd0);
        check("t5_hex0", 32'(bus.hex[0]), 32'h40);
        check("t5_hex1", 32'(bus.hex[1]), 32'h7F);
        @(negedge clk);
        #2 reset = 1'b0;
        wait_done(c);
        check("t5_bcd777", 32'(bus.bcd), 32'h00777);
        bus.start = 1'b1;
        for (int v = 0; v < 16384 + 7; v += 7) begin
            int val;
            val = v > 16383 ? 16383 : v;
            bus.count = 14'(val);
            wait_done(c);
            check("sweep_period", 32'(c), 32'd16);
            check("sweep_bcd", 32'(bus.bcd), 32'(to_bcd(val)));
        end
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
